// File: rtl/router_out_drain.sv
// Drains one router output FIFO onto a valid/ready byte port, tags header/parity bytes,
// checks packet parity and flushes the FIFO on a stalled destination. Stats: ROUTER_OUT_STATS_EN.
module router_out_drain #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_read_enb,
  output logic             fifo_soft_reset,
  input  logic             read_in,
  output logic             vld_out,
  output logic [7:0]       data_out,
  output logic             sop,
  output logic             eop,
  output logic             parity_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int STW = $clog2(TIMEOUT + 1);
  localparam logic [STW-1:0] STALL_MAX  = STW'(TIMEOUT);
  localparam logic [STW-1:0] STALL_FIRE = STW'(TIMEOUT - 1);

  // state  | meaning
  // S_IDLE | next captured byte is a header;  S_PAY | payload bytes or the parity byte pending
  typedef enum logic {S_IDLE, S_PAY} state_t;

  state_t         state_q, state_d;
  logic [5:0]     rem_q, rem_d;
  logic [7:0]     acc_q, acc_d;
  logic [1:0]     occ_q, occ_d;
  logic [10:0]    ent0_q, ent0_d, ent1_q, ent1_d;  // {mismatch, sop, eop, byte}
  logic           infl_q;
  logic [STW-1:0] stall_q, stall_d;
  logic           soft_q;
  logic           perr_q, perr_d;
  logic           xfer;
  logic           timeout_fire;
  logic [1:0]     occ_left;
  logic [10:0]    cap_ent;

  assign vld_out      = (occ_q != 2'd0);
  assign xfer         = vld_out && read_in;
  assign timeout_fire = vld_out && !read_in && (stall_q == STALL_FIRE);
  assign occ_left     = occ_q - {1'b0, xfer};

  // Reads are also held off during the flush pulse so nothing from the old FIFO contents lands.
  assign fifo_read_enb = rstn && !fifo_empty && !timeout_fire && !soft_q &&
                         ((occ_left + {1'b0, infl_q}) < 2'd2);

  assign data_out        = vld_out ? ent0_q[7:0] : 8'h00;
  assign sop             = vld_out && ent0_q[9];
  assign eop             = vld_out && ent0_q[8];
  assign fifo_soft_reset = soft_q;
  assign parity_err      = perr_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cap_ent = '0;
    if (infl_q) begin
      case (state_q)
        S_IDLE: begin
          cap_ent = {1'b0, 1'b1, 1'b0, fifo_dout};
          rem_d   = fifo_dout[7:2];
          acc_d   = fifo_dout;
          state_d = S_PAY;
        end
        S_PAY: begin
          if (rem_q != 6'd0) begin
            cap_ent = {1'b0, 1'b0, 1'b0, fifo_dout};
            acc_d   = acc_q ^ fifo_dout;
            rem_d   = rem_q - 6'd1;
          end else begin
            cap_ent = {(acc_q != fifo_dout), 1'b0, 1'b1, fifo_dout};
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (timeout_fire) state_d = S_IDLE;
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (xfer) ent0_d = ent1_q;
    if (infl_q) begin
      if (occ_left == 2'd0) ent0_d = cap_ent;
      else                  ent1_d = cap_ent;
    end
    occ_d = occ_left + {1'b0, infl_q};
    if (timeout_fire) occ_d = 2'd0;
  end

  always_comb begin
    stall_d = stall_q;
    if (!vld_out || xfer || timeout_fire) stall_d = '0;
    else if (stall_q != STALL_MAX)        stall_d = stall_q + STW'(1);
    perr_d = xfer && ent0_q[8] && ent0_q[10];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      occ_q   <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      infl_q  <= 1'b0;
      stall_q <= '0;
      soft_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      occ_q   <= occ_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      infl_q  <= fifo_read_enb;
      stall_q <= stall_d;
      soft_q  <= timeout_fire;
      perr_q  <= perr_d;
    end
  end

`ifdef ROUTER_OUT_STATS_EN
  logic [CNT_W-1:0] pkt_q;
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_q <= '0;
      err_q <= '0;
    end else begin
      if (xfer && ent0_q[8]) pkt_q <= pkt_q + CNT_W'(1);
      err_q <= err_q + CNT_W'(perr_q) + CNT_W'(soft_q);
    end
  end

  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_out_drain.sv
// Bench for router_out_drain: behavioural FIFO, packet-level expected byte stream, scenario tasks.
module tb_router_out_drain;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_dout = 8'h00;
  logic             read_in = 1'b0;
  logic             fifo_read_enb, fifo_soft_reset, vld_out, sop, eop, parity_err;
  logic [7:0]       data_out;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  router_out_drain #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read_enb(fifo_read_enb), .fifo_soft_reset(fifo_soft_reset), .read_in(read_in),
    .vld_out(vld_out), .data_out(data_out), .sop(sop), .eop(eop), .parity_err(parity_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  typedef struct packed {logic [7:0] data; logic sop; logic eop; logic perr;} xfer_t;

  xfer_t      exp_q[$];
  xfer_t      obs_q[$];
  logic [7:0] src_q[$];
  logic [7:0] fq[$];
  logic [7:0] pay_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, outst = 0, max_outst = 0, stray_perr = 0, perr_pulses = 0, sr_pulses = 0;
  int last_xf_cyc = -10;
  logic last_xf_eop = 1'b0;
  int m_pkt = 0, m_err = 0;

  // 16-deep FIFO with registered read data, fed from src_q by the upstream writer
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rstn || fifo_soft_reset) begin
      fq.delete();
      fifo_dout  <= 8'($urandom);
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read_enb && fq.size() > 0) fifo_dout <= fq.pop_front();
      else                                fifo_dout <= 8'($urandom);
      while (fq.size() < 16 && src_q.size() > 0) fq.push_back(src_q.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    xfer_t t;
    if (!rstn) begin
      outst = 0;
      last_xf_eop = 1'b0;
    end else begin
      if (fifo_soft_reset) begin
        outst = 0;
        sr_pulses++;
      end
      if (parity_err) begin
        perr_pulses++;
        if (obs_q.size() > 0 && last_xf_eop && last_xf_cyc == cyc - 1) begin
          t = obs_q[obs_q.size()-1];
          t.perr = 1'b1;
          obs_q[obs_q.size()-1] = t;
        end else stray_perr++;
      end
      if (vld_out && read_in) begin
        obs_q.push_back({data_out, sop, eop, 1'b0});
        last_xf_cyc = cyc;
        last_xf_eop = eop;
      end
      outst = outst + int'(fifo_read_enb) - int'(vld_out && read_in);
      if (outst > max_outst) max_outst = outst;
    end
  end

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef ROUTER_OUT_STATS_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  task automatic clear_sb();
    obs_q.delete(); exp_q.delete(); pay_q.delete();
    stray_perr = 0; perr_pulses = 0; sr_pulses = 0; max_outst = 0;
  endtask

  // Expected stream follows the packet rules: header, hdr[7:2] payload bytes, XOR parity byte.
  task automatic add_pkt(input logic [7:0] hdr, input logic force_par, input logic [7:0] par_val);
    logic [7:0] acc, b;
    acc = hdr;
    src_q.push_back(hdr);
    exp_q.push_back({hdr, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      if (pay_q.size() > 0) b = pay_q.pop_front();
      else                  b = 8'($urandom);
      acc = acc ^ b;
      src_q.push_back(b);
      exp_q.push_back({b, 1'b0, 1'b0, 1'b0});
    end
    b = force_par ? par_val : acc;
    src_q.push_back(b);
    exp_q.push_back({b, 1'b0, 1'b1, (b != acc)});
  endtask

  task automatic account();
    foreach (exp_q[i]) begin
      if (exp_q[i].eop)  m_pkt++;
      if (exp_q[i].perr) m_err++;
    end
  endtask

  // mode 0: ready held high, 1: toggling, 2: random ~60% ready
  task automatic run_until_drained(input int mode, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (mode == 0)      read_in = 1'b1;
      else if (mode == 1) read_in = (i % 2) == 0;
      else                read_in = ($urandom_range(0, 99) < 60);
      if (obs_q.size() >= exp_q.size() && src_q.size() == 0 && !vld_out && i > 4) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; read_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({vld_out, fifo_read_enb, fifo_soft_reset, parity_err, sop, eop, data_out, pkt_cnt, err_cnt} !== '0)
      $display("FAIL reset_outputs: got vld=%b rd=%b sr=%b perr=%b sop=%b eop=%b data=%h pkt=%0d err=%0d want all 0",
               vld_out, fifo_read_enb, fifo_soft_reset, parity_err, sop, eop, data_out, pkt_cnt, err_cnt);
    else n_pass++;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({vld_out, fifo_read_enb} !== 2'b00)
      $display("FAIL idle_after_reset: got vld=%b rd=%b want 0 0", vld_out, fifo_read_enb);
    else n_pass++;
  endtask

  task automatic test_basic_packet();
    logic ok;
    int t_ne, t_v, n_v, t_last;
    clear_sb();
    @(posedge clk); #1 read_in = 1'b1;
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    add_pkt(8'h0C, 1'b0, 8'h00);
    t_ne = -1; t_v = -1; n_v = 0; t_last = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!fifo_empty && t_ne < 0) t_ne = cyc;
      if (vld_out) begin
        if (t_v < 0) t_v = cyc;
        n_v++;
        t_last = cyc;
      end
    end
    run_until_drained(0, 50, ok);
    n_checks++;
    if (t_v - t_ne !== 2) $display("FAIL basic_latency: got %0d cycles want 2", t_v - t_ne);
    else n_pass++;
    n_checks++;
    if (n_v !== 5 || t_last - t_v + 1 !== 5)
      $display("FAIL basic_vld_run: got %0d vld cycles over span %0d want 5 consecutive", n_v, t_last - t_v + 1);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL basic_len: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    account();
    n_checks++;
    if (perr_pulses !== 0) $display("FAIL basic_no_perr: got %0d pulses want 0", perr_pulses);
    else n_pass++;
    n_checks++;
    if (pkt_cnt !== exp_cnt(m_pkt)) $display("FAIL basic_pkt_cnt: got %0d want %0d", pkt_cnt, exp_cnt(m_pkt));
    else n_pass++;
  endtask

  task automatic test_parity_error();
    logic ok;
    clear_sb();
    @(posedge clk); #1 read_in = 1'b1;
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    add_pkt(8'h0C, 1'b1, 8'hFF);
    run_until_drained(0, 50, ok);
    n_checks++;
    if (!ok) $display("FAIL perr_drain: got timeout want drained");
    else n_pass++;
    n_checks++;
    if (perr_pulses !== 1 || stray_perr !== 0)
      $display("FAIL perr_pulse: got %0d pulses (%0d misplaced) want 1 after eop", perr_pulses, stray_perr);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 5 || obs_q[4] !== exp_q[4])
      $display("FAIL perr_eop_entry: got %0d bytes last %h want 5 bytes last %h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 11'h0, exp_q[4]);
    else n_pass++;
    account();
    n_checks++;
    if (err_cnt !== exp_cnt(m_err)) $display("FAIL perr_err_cnt: got %0d want %0d", err_cnt, exp_cnt(m_err));
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic ok, seen;
    int n_v;
    clear_sb();
    @(posedge clk); #1 read_in = 1'b0;
    add_pkt(8'h0C, 1'b0, 8'h00);
    n_v = 0; seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (fifo_soft_reset) begin
        seen = 1'b1;
        n_checks++;
        if ({fifo_read_enb, vld_out} !== 2'b00)
          $display("FAIL to_pulse_cycle: got rd=%b vld=%b want 0 0", fifo_read_enb, vld_out);
        else n_pass++;
      end else if (vld_out) n_v++;
    end
    n_checks++;
    if (!seen || n_v !== TIMEOUT)
      $display("FAIL to_stall_cycles: got pulse=%b after %0d stalled cycles want 1 after %0d", seen, n_v, TIMEOUT);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({fifo_soft_reset, vld_out} !== 2'b00)
      $display("FAIL to_after_pulse: got sr=%b vld=%b want 0 0", fifo_soft_reset, vld_out);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sr_pulses !== 1 || obs_q.size() !== 0 || vld_out !== 1'b0)
      $display("FAIL to_flush: got %0d pulses, %0d bytes, vld=%b want 1, 0, 0", sr_pulses, obs_q.size(), vld_out);
    else n_pass++;
    m_err++;
    n_checks++;
    if (err_cnt !== exp_cnt(m_err)) $display("FAIL to_err_cnt: got %0d want %0d", err_cnt, exp_cnt(m_err));
    else n_pass++;
    clear_sb();
    @(posedge clk); #1;
    add_pkt(8'h08, 1'b0, 8'h00);
    run_until_drained(0, 60, ok);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL to_recover_len: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL to_recover[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    account();
  endtask

  task automatic test_toggle();
    logic ok;
    clear_sb();
    @(posedge clk); #1;
    add_pkt(8'h20, 1'b0, 8'h00);
    run_until_drained(1, 100, ok);
    n_checks++;
    if (obs_q.size() !== 10) $display("FAIL toggle_len: got %0d want 10", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL toggle_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (max_outst > 2) $display("FAIL toggle_outstanding: got %0d want <= 2", max_outst);
    else n_pass++;
    account();
  endtask

  task automatic test_zero_len();
    logic ok;
    clear_sb();
    @(posedge clk); #1;
    add_pkt(8'h00, 1'b1, 8'h00);
    run_until_drained(0, 40, ok);
    n_checks++;
    if (obs_q.size() !== 2) $display("FAIL zero_len: got %0d bytes want 2", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL zero_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    account();
    n_checks++;
    if (pkt_cnt !== exp_cnt(m_pkt)) $display("FAIL zero_pkt_cnt: got %0d want %0d", pkt_cnt, exp_cnt(m_pkt));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ok;
    clear_sb();
    @(posedge clk); #1 read_in = 1'b1;
    add_pkt(8'hFC, 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    src_q.delete();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({vld_out, fifo_read_enb, fifo_soft_reset, parity_err, sop, eop, data_out, pkt_cnt, err_cnt} !== '0)
        $display("FAIL midreset_outputs[%0d]: got vld=%b rd=%b sr=%b data=%h pkt=%0d want all 0",
                 i, vld_out, fifo_read_enb, fifo_soft_reset, data_out, pkt_cnt);
      else n_pass++;
    end
    m_pkt = 0; m_err = 0;
    @(posedge clk); #1 rstn = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    add_pkt(8'h14, 1'b0, 8'h00);
    run_until_drained(0, 60, ok);
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0].sop !== 1'b1 || obs_q[0].data !== 8'h14)
      $display("FAIL midreset_first_sop: got %0d bytes first %h want header 14 with sop", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 11'h0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size() || sr_pulses !== 0)
      $display("FAIL midreset_stream: got %0d bytes %0d flushes want %0d bytes 0 flushes", obs_q.size(), sr_pulses, exp_q.size());
    else n_pass++;
    account();
    n_checks++;
    if (pkt_cnt !== exp_cnt(m_pkt)) $display("FAIL midreset_pkt_cnt: got %0d want %0d", pkt_cnt, exp_cnt(m_pkt));
    else n_pass++;
  endtask

  task automatic test_random();
    logic ok;
    int n, errs;
    for (int r = 0; r < 4; r++) begin
      clear_sb();
      @(posedge clk); #1;
      n = $urandom_range(3, 5);
      for (int p = 0; p < n; p++)
        add_pkt((r == 0 && p == 0) ? 8'hFF : 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
      run_until_drained(2, exp_q.size() * 8 + 200, ok);
      n_checks++;
      if (!ok || obs_q.size() !== exp_q.size())
        $display("FAIL rand%0d_len: got %0d want %0d", r, obs_q.size(), exp_q.size());
      else n_pass++;
      errs = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) begin
          if (errs == 0) $display("FAIL rand%0d_byte[%0d]: got %h want %h", r, i, obs_q[i], exp_q[i]);
          errs++;
        end
      n_checks++;
      if (errs !== 0) $display("FAIL rand%0d_stream: got %0d wrong bytes want 0", r, errs);
      else n_pass++;
      n_checks++;
      if (max_outst > 2 || stray_perr !== 0 || sr_pulses !== 0)
        $display("FAIL rand%0d_protocol: got outst=%0d stray_perr=%0d flushes=%0d want <=2 0 0",
                 r, max_outst, stray_perr, sr_pulses);
      else n_pass++;
      account();
      n_checks++;
      if (pkt_cnt !== exp_cnt(m_pkt) || err_cnt !== exp_cnt(m_err))
        $display("FAIL rand%0d_counters: got pkt=%0d err=%0d want %0d %0d", r, pkt_cnt, err_cnt,
                 exp_cnt(m_pkt), exp_cnt(m_err));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_parity_error();
    test_timeout();
    test_toggle();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
